// File: rtl/blind_pixel_detect.sv
// Blind-pixel calibration scanner: video passes through with 1-cycle latency while one armed frame
// is scanned; table written as addr 1..N = indices, then addr 0 = N. Optional macro: BP_DETECT_NEIGHBOUR_EN.
module blind_pixel_detect #(
    parameter int DATA_WIDTH  = 14,
    parameter int MAX_ENTRIES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reg_start,
    input  logic [DATA_WIDTH-1:0] reg_thresh_lo,
    input  logic [DATA_WIDTH-1:0] reg_thresh_hi,
    input  logic [DATA_WIDTH-1:0] reg_delta,
    output logic                  stat_busy,
    output logic                  stat_done,
    output logic                  stat_overflow,
    output logic [7:0]            stat_count,
    output logic                  ram_write,
    output logic [7:0]            ram_address,
    output logic [31:0]           ram_writedata,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_valid,
    input  logic                  din_startofpacket,
    input  logic                  din_endofpacket,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    input  logic                  dout_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_SCAN  = 2'd2,
        S_WRCNT = 2'd3
    } state_t;

    localparam logic [7:0] LP_MAX = 8'(MAX_ENTRIES);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_dout_data;
    logic                  r_dout_valid;
    logic                  r_dout_sop;
    logic                  r_dout_eop;
    logic [31:0]           r_pix_idx;
    logic [7:0]            r_count;
    logic                  r_done;
    logic                  r_overflow;
    logic                  r_ram_write;
    logic [7:0]            r_ram_address;
    logic [31:0]           r_ram_writedata;

    logic        w_accept;
    logic [31:0] w_idx;
    logic        w_flag_thr;
    logic        w_flag_nb;
    logic        w_flag;
    logic        w_eval;
    logic        w_restart;
    logic [7:0]  w_cnt_base;
    logic        w_room;

    assign din_ready = dout_ready | ~r_dout_valid;
    assign w_accept  = din_valid & din_ready;
    assign w_idx     = din_startofpacket ? 32'd0 : r_pix_idx;

    assign w_flag_thr = (din_data < reg_thresh_lo) | (din_data > reg_thresh_hi);

`ifdef BP_DETECT_NEIGHBOUR_EN
    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_prev_vld;
    logic [DATA_WIDTH-1:0] w_diff;

    assign w_diff    = (din_data >= r_prev) ? (din_data - r_prev) : (r_prev - din_data);
    assign w_flag_nb = ~din_startofpacket & r_prev_vld & (w_diff > reg_delta);

    // prev is only meaningful inside a frame; EOP invalidates it for stray beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
        end else if (w_accept) begin
            r_prev     <= din_data;
            r_prev_vld <= ~din_endofpacket;
        end
    end
`else
    logic w_unused_delta;
    assign w_unused_delta = ^reg_delta;
    assign w_flag_nb      = 1'b0;
`endif

    assign w_flag     = w_flag_thr | w_flag_nb;
    assign w_eval     = w_accept & (((r_state == S_ARM) & din_startofpacket) | (r_state == S_SCAN));
    assign w_restart  = (r_state == S_SCAN) & din_startofpacket;
    assign w_cnt_base = w_restart ? 8'd0 : r_count;
    assign w_room     = w_cnt_base < LP_MAX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout_data  <= '0;
            r_dout_valid <= 1'b0;
            r_dout_sop   <= 1'b0;
            r_dout_eop   <= 1'b0;
            r_pix_idx    <= 32'd0;
        end else begin
            if (din_ready) begin
                r_dout_valid <= din_valid;
            end
            if (w_accept) begin
                r_dout_data <= din_data;
                r_dout_sop  <= din_startofpacket;
                r_dout_eop  <= din_endofpacket;
                r_pix_idx   <= w_idx + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_count         <= 8'd0;
            r_done          <= 1'b0;
            r_overflow      <= 1'b0;
            r_ram_write     <= 1'b0;
            r_ram_address   <= 8'd0;
            r_ram_writedata <= 32'd0;
        end else begin
            r_ram_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (reg_start) begin
                        r_state    <= S_ARM;
                        r_count    <= 8'd0;
                        r_done     <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end
                S_ARM, S_SCAN: begin
                    if (w_eval) begin
                        if (w_restart) begin
                            r_count    <= 8'd0;
                            r_overflow <= 1'b0;
                        end
                        if (w_flag) begin
                            if (w_room) begin
                                r_ram_write     <= 1'b1;
                                r_ram_address   <= w_cnt_base + 8'd1;
                                r_ram_writedata <= w_idx;
                                r_count         <= w_cnt_base + 8'd1;
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end
                        r_state <= din_endofpacket ? S_WRCNT : S_SCAN;
                    end
                end
                S_WRCNT: begin
                    // the last entry write issued on the EOP edge, so this one lands strictly after it
                    r_ram_write     <= 1'b1;
                    r_ram_address   <= 8'd0;
                    r_ram_writedata <= {24'd0, r_count};
                    r_done          <= 1'b1;
                    r_state         <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stat_busy          = (r_state != S_IDLE);
    assign stat_done          = r_done;
    assign stat_overflow      = r_overflow;
    assign stat_count         = r_count;
    assign ram_write          = r_ram_write;
    assign ram_address        = r_ram_address;
    assign ram_writedata      = r_ram_writedata;
    assign dout_data          = r_dout_data;
    assign dout_valid         = r_dout_valid;
    assign dout_startofpacket = r_dout_sop;
    assign dout_endofpacket   = r_dout_eop;

endmodule
